multu_hilo_unit: RTL and testbench
==================================

Name: multu_hilo_unit

Overview:
Sequential unsigned multiplier and HI/LO register pair for the MIPS datapath. It consumes the MULTU write-enable produced by the ALU auxiliary decoder and serves MFHI/MFLO reads of HI/LO. It sits beside the ALU in the execute stage. It raises a stall to the controller while a read or a new MULTU would collide with a multiply in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; multiply latency is WIDTH cycles.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
mult_we  input  1  MULTU issue strobe from the decoder; sampled each rising edge
a  input  WIDTH  multiplicand (rs value), sampled on the accepting edge
b  input  WIDTH  multiplier (rt value), sampled on the accepting edge
hilo_rd  input  1  high when the current instruction is MFHI or MFLO (result_op = 01 or 10)
hi  output  WIDTH  architectural HI register
lo  output  WIDTH  architectural LO register
busy  output  1  multiply in progress
done  output  1  one-cycle pulse in the cycle after HI/LO are updated
stall  output  1  combinational: busy & (mult_we | hilo_rd)

Behaviour:
- Clocking and reset: one clock (clk), asynchronous active-high reset (rst).
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, state = IDLE, counter = 0, internal accumulator and operands = 0.
- State machine has two states, IDLE and RUN.
- IDLE, on an edge with mult_we = 1:
  - latch mcand = a and mplier = b, clear acc (WIDTH+1 bits), set counter = WIDTH-1;
  - go to RUN; busy = 1 from the next cycle.
- RUN, each edge performs one shift-add step:
  - sum = acc + (mplier[0] ? mcand : 0), computed at WIDTH+1 bits;
  - shift {sum, mplier} right by 1 into {acc, mplier}; the carry bit enters acc MSB.
- RUN, on the edge where counter = 0:
  - perform the final step;
  - write hi = upper WIDTH bits of the result and lo = lower WIDTH bits;
  - go to IDLE, busy = 0, done = 1 for exactly one cycle.
- RUN, other edges: counter decrements by 1.
- Latency: the accepting edge is E0. HI/LO hold the new product after edge E0+WIDTH. busy is high for exactly WIDTH cycles.
- HI/LO are architectural state and keep their old values throughout RUN. No partial result is ever visible on hi/lo.
- Result is the full 2·WIDTH-bit unsigned product. No truncation or overflow flag.
- mult_we while busy: ignored by the FSM. stall is asserted so the controller holds the instruction and re-presents it. It is accepted on the first edge after busy falls.
- hilo_rd while busy: stall asserted. Once busy = 0, hi/lo are directly readable in that same cycle; this covers the completion cycle onward.
- hilo_rd and mult_we never change HI/LO by themselves; only completion writes them.
- mult_we in the same cycle as the completing edge: not accepted, because busy was 1 during that cycle; it is re-presented under stall.
- done and mult_we in the same cycle: the new multiply is accepted while done is high. done still drops on the next edge.
- rst asserted mid-RUN: immediately abort, and all registers return to reset values, including hi/lo = 0.
- stall is purely combinational from registered busy plus inputs. No path from stall back into mult_we exists inside the block.

Test Plan:
- Reset, then mult_we with a=3, b=5 for one cycle. Required: busy high for 32 cycles; after edge E0+32, hi=0x00000000 and lo=0x0000000F; done pulses once; busy=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001 at E0+32; carry path into acc MSB exercised.
- a=0x80000000, b=0x00000002, then a=0, b=0x12345678. Required: first result hi=0x00000001, lo=0x00000000; second result hi=0, lo=0.
- Complete 7×6 (lo=0x2A), then start 0x10000×0x10000 and assert hilo_rd at cycle 5 of RUN. Required: stall=1 while busy, hi/lo still show 0/0x2A; after completion hi=0x00000001, lo=0, stall=0.
- Back-to-back: mult_we held high for 40 cycles with a=2, b=9, then a=4, b=4. Required: stall=1 during the first RUN; the second multiply is accepted the edge after busy falls; final lo=0x10 after the second completion.
- Start 0xDEADBEEF×0x1000 and assert rst asynchronously at RUN cycle 10, mid-clock. Required: busy, done, hi, lo all 0 immediately; a fresh 3×5 afterwards yields lo=0xF.

Source files
------------

// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: sequential shift-add unsigned multiplier with architectural HI/LO registers
module multu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mult_we,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, mplier_d, hi_q, lo_q;
  logic [WIDTH:0]   acc_q, acc_d, sum;
  logic             done_q;
  // one shift-add step; the adder carry lands in the accumulator so no product bit is lost
  always_comb begin
    sum = acc_q + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    {acc_d, mplier_d} = {1'b0, sum, mplier_q[WIDTH-1:1]};
  end
  // IDLE/RUN sequencer; HI/LO are only written on the final step so partial products stay hidden
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      done_q <= 1'b0;
      if (mult_we) begin
        mcand_q  <= a;
        mplier_q <= b;
        acc_q    <= '0;
        cnt_q    <= CW'(WIDTH - 1);
        state_q  <= RUN;
      end
    end else begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      if (cnt_q == '0) begin
        hi_q    <= acc_d[WIDTH-1:0];
        lo_q    <= mplier_d;
        done_q  <= 1'b1;
        state_q <= IDLE;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN);
  assign stall = busy & (mult_we | hilo_rd);
endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb_multu_hilo_unit: directed and random checks of multu_hilo_unit against a 64-bit arithmetic model
module tb_multu_hilo_unit;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mult_we = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hilo_rd = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall;
  int           total = 0;
  int           passed = 0;
  int           failed = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  multu_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mult_we(mult_we), .a(a), .b(b), .hilo_rd(hilo_rd),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // issue one multiply, check busy length, HI/LO hold during RUN, result and done pulse
  task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    logic [63:0] p;
    int n;
    p = {32'b0, x} * {32'b0, y};
    @(negedge clk);
    mult_we = 1'b1; a = x; b = y;
    @(negedge clk);
    mult_we = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (n == W / 2) chk({tag, "_hold"}, {hi, lo}, {hi_m, lo_m});
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(W));
    hi_m = p[63:32];
    lo_m = p[31:0];
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    chk({tag, "_hilo"}, {hi, lo}, p);
    @(negedge clk);
    chk({tag, "_done_drop"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int n;
    logic [W-1:0] rx, ry;
    repeat (3) @(negedge clk);
    mult_we = 1'b1;
    #1;
    chk("reset_state", {hi, lo}, 64'd0);
    chk("reset_flags", {61'b0, busy, done, stall}, 64'd0);
    mult_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_mult(32'd3, 32'd5, "m3x5");
    chk("m3x5_val", {hi, lo}, 64'h0000_0000_0000_000F);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mff");
    chk("mff_val", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_mult(32'h8000_0000, 32'd2, "mmsb");
    chk("mmsb_val", {hi, lo}, 64'h0000_0001_0000_0000);
    do_mult(32'd0, 32'h1234_5678, "mzero");

    for (int i = 0; i < 6; i++) begin
      rx = $urandom;
      ry = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      do_mult(rx, ry, $sformatf("rnd%0d", i));
    end

    do_mult(32'd7, 32'd6, "m7x6");
    @(negedge clk);
    mult_we = 1'b1; a = 32'h1_0000; b = 32'h1_0000;
    @(negedge clk);
    mult_we = 1'b0;
    repeat (4) @(negedge clk);
    hilo_rd = 1'b1;
    #1;
    chk("rd_stall", {63'b0, stall}, 64'd1);
    chk("rd_old_hilo", {hi, lo}, {32'd0, 32'h2A});
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rd_wait", {63'b0, busy}, 64'd0);
    chk("rd_new_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
    chk("rd_stall_clear", {63'b0, stall}, 64'd0);
    hilo_rd = 1'b0;
    hi_m = 32'd1; lo_m = 32'd0;

    @(negedge clk);
    mult_we = 1'b1; a = 32'd2; b = 32'd9;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin a = 32'd4; b = 32'd4; end
      chk($sformatf("b2b_busy%0d", i), {63'b0, busy}, {63'b0, (i != W)});
      chk($sformatf("b2b_stall%0d", i), {63'b0, stall}, {63'b0, (i != W)});
      if (i == W) chk("b2b_first", {hi, lo, 31'b0, done}, {32'd0, 32'd18, 31'b0, 1'b1});
    end
    mult_we = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second", {hi, lo}, 64'd16);
    chk("b2b_done", {63'b0, done}, 64'd1);

    @(negedge clk);
    mult_we = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1000;
    @(negedge clk);
    mult_we = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_clear", {hi, lo, 30'b0, busy, done}, 96'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    rst = 1'b0;
    do_mult(32'd3, 32'd5, "post_rst");
    chk("post_rst_val", {hi, lo}, 64'h0000_0000_0000_000F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
